// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared types and constants for the hex display scheduler
package hex_display_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int DIGIT_W = 7;
  localparam int NIBBLE_W = 4;
  localparam logic [DIGIT_W-1:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/hex_display_sched_if.sv
// hex_display_sched_if: value handshake and display outputs of the hex display scheduler
interface hex_display_sched_if #(parameter int NUM_DIGITS = 8);
  logic [4*NUM_DIGITS-1:0] in_value;
  logic in_valid;
  logic in_ready;
  logic [7*NUM_DIGITS-1:0] seg_out;
  logic busy;
  logic done;
  modport master(output in_value, in_valid, input in_ready, seg_out, busy, done);
  modport slave(input in_value, in_valid, output in_ready, seg_out, busy, done);
endinterface

// File: rtl/hexadigit8.sv
// hexadigit8: hex nibble to active-low seven-segment pattern (bit0 = a .. bit6 = g)
module hexadigit8
  import hex_display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [DIGIT_W-1:0]  seg
);
  localparam logic [DIGIT_W-1:0] LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  assign seg = LUT[nibble];
endmodule

// File: rtl/hex_display_sched.sv
// hex_display_sched: time-shares one hex decoder over NUM_DIGITS segment registers, MSB first; HEX_LEADING_ZERO_BLANK_EN blanks leading zeros
module hex_display_sched
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input logic clk,
  input logic rst,
  hex_display_sched_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [NIBBLE_W*NUM_DIGITS-1:0] shadow;
  logic [DIGIT_W*NUM_DIGITS-1:0] seg;
  logic [NIBBLE_W-1:0] nib;
  logic [DIGIT_W-1:0] dec, pat;
  logic accept;
  assign accept = state == IDLE && bus.in_valid;
  assign nib = shadow[idx*NIBBLE_W +: NIBBLE_W];
  hexadigit8 u_dec (.nibble(nib), .seg(dec));
`ifdef HEX_LEADING_ZERO_BLANK_EN
  logic seen_nonzero;
  always_ff @(posedge clk)
    if (rst || accept) seen_nonzero <= 1'b0;
    else if (state == SCAN && nib != '0) seen_nonzero <= 1'b1;
  assign pat = (!seen_nonzero && nib == '0 && idx != '0) ? SEG_BLANK : dec;
`else
  assign pat = dec;
`endif
  always_comb begin
    state_nx = accept ? SCAN :
               (state == SCAN && idx == '0) ? DONE :
               (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      shadow <= '0;
      seg <= '1;
    end else begin
      state <= state_nx;
      if (accept) begin
        shadow <= bus.in_value;
        idx <= IDX_W'(NUM_DIGITS - 1);
      end
      if (state == SCAN) begin
        seg[idx*DIGIT_W +: DIGIT_W] <= pat;
        idx <= idx - 1'b1;
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state == SCAN;
  assign bus.done = state == DONE;
  assign bus.seg_out = seg;
endmodule

// File: tb/tb_hex_display_sched.sv
// tb_hex_display_sched: directed checks of the hex display scheduler
module tb_hex_display_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  hex_display_sched_if #(.NUM_DIGITS(8)) bus ();
  hex_display_sched #(.NUM_DIGITS(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [31:0] v);
    bus.in_value = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    chk("scan_done", bus.done, 1);
    tick();
  endtask

  initial begin
    bus.in_value = '0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_seg", bus.seg_out, {56{1'b1}});
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    bus.in_value = 32'h12345678;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("e0_busy", bus.busy, 1);
    chk("e0_ready", bus.in_ready, 0);
    chk("e0_seg", bus.seg_out, {56{1'b1}});
    tick();
    chk("e1_dig7", bus.seg_out[55:49], 7'h79);
    chk("e1_rest", bus.seg_out[48:0], {49{1'b1}});
    repeat (6) tick();
    chk("e7_done", bus.done, 0);
    chk("e7_busy", bus.busy, 1);
    tick();
    chk("e8_seg", bus.seg_out, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    chk("e8_dig0", bus.seg_out[6:0], 7'h00);
    chk("e8_done", bus.done, 1);
    chk("e8_busy", bus.busy, 0);
    tick();
    chk("e9_done", bus.done, 0);
    chk("e9_ready", bus.in_ready, 1);

    bus.in_value = 32'hFFFFFFFF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_value = 32'hA5A5A5A5;
    repeat (8) tick();
    chk("hold1_seg", bus.seg_out, {8{7'h0E}});
    chk("hold1_done", bus.done, 1);
    tick();
    chk("hold_ready", bus.in_ready, 1);
    tick();
    chk("hold2_busy", bus.busy, 1);
    bus.in_valid = 1'b0;
    repeat (8) tick();
    chk("hold2_seg", bus.seg_out, {4{7'h08, 7'h12}});
    chk("hold2_done", bus.done, 1);
    tick();

    bus.in_value = 32'hDEADBEEF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_dig7", bus.seg_out[55:49], 7'h21);
    chk("mid_dig6", bus.seg_out[48:42], 7'h06);
    chk("mid_dig4", bus.seg_out[34:28], 7'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_seg", bus.seg_out, {56{1'b1}});
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_done", bus.done, 0);
    chk("mrst_busy", bus.busy, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_nodone", bus.done, 0);
    end
    chk("mrst_seg_hold", bus.seg_out, {56{1'b1}});

`ifdef HEX_LEADING_ZERO_BLANK_EN
    run_scan(32'h000000A5);
    chk("lz_a5", bus.seg_out, {{6{7'h7F}}, 7'h08, 7'h12});
    run_scan(32'h00000000);
    chk("lz_zero", bus.seg_out, {{7{7'h7F}}, 7'h40});
    run_scan(32'h00F0000C);
    chk("lz_inner", bus.seg_out, {{2{7'h7F}}, 7'h0E, {4{7'h40}}, 7'h46});
`else
    run_scan(32'h00000000);
    chk("nz_zero", bus.seg_out, {8{7'h40}});
    run_scan(32'h000000A5);
    chk("nz_a5", bus.seg_out, {{6{7'h40}}, 7'h08, 7'h12});
    run_scan(32'h9BCD0E37);
    chk("nz_mix", bus.seg_out, {7'h10, 7'h03, 7'h46, 7'h21, 7'h40, 7'h06, 7'h30, 7'h78});
`endif
    chk("end_ready", bus.in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hex_display_sched.md
# hex_display_sched

Display scheduler that time-shares one hex-to-seven-segment decoder across the board's eight HEX digits. It accepts a 32-bit value, such as an LFSR state, over a valid/ready handshake. It walks the nibbles MSB-first through the single decoder and latches each decoded pattern into that digit's segment register. It sits between the value source (LFSR or counter) and the HEX pins, and holds the display stable between updates.

## Interface
- NUM_DIGITS, 8, number of digits driven; value width is 4*NUM_DIGITS
- clk  in  1  system clock (50 MHz board clock)
- rst  in  1  synchronous, active-high reset
- in_value  in  4*NUM_DIGITS  value to display; nibble k goes to digit k
- in_valid  in  1  in_value is presented
- in_ready  out  1  block can accept a value; high only in IDLE
- seg_out  out  7*NUM_DIGITS  active-low segments; digit k at [7k+6:7k]; bit0 = segment a … bit6 = segment g
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the last digit is written

## Operation
- Reset values:
  - seg_out all ones (all digits dark).
  - in_ready = 1, busy = 0, done = 0.
  - State IDLE, shadow register 0.
- States and transitions:
  - IDLE to SCAN on in_valid & in_ready. in_value is captured into the shadow register. Digit index is set to NUM_DIGITS-1.
  - SCAN: each cycle the decoder input is shadow nibble[idx]. The decoded pattern is written to digit idx at the next edge and idx is decremented.
  - SCAN with idx == 0: write digit 0, then go to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE unconditionally.
- in_value and in_valid are ignored outside IDLE. There is no queuing. A source holding in_valid is accepted on the first IDLE cycle.
- Decoder patterns, active-low g..a: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, B=0x03, C=0x46, D=0x21, E=0x06, F=0x0E.
- Digits not yet rewritten keep their previous pattern during SCAN. There is no intermediate blanking.
- Reset mid-scan:
  - All digits go dark at the next edge and the state returns to IDLE.
  - Partially written values are discarded. No done pulse is produced.

## Timing
- Accept edge E0. Digit NUM_DIGITS-1 is updated at E0+1, and digit k at E0+NUM_DIGITS-k.
- Digit 0 is updated at edge E0+NUM_DIGITS.
- done is high in the cycle after E0+NUM_DIGITS.
- in_ready is high again one cycle after done.
- Accept-to-accept minimum is NUM_DIGITS+2 cycles (10 for the default).
- busy is high from E0+1 through edge E0+NUM_DIGITS inclusive.
- All outputs are registered. The only combinational path is shadow nibble → decoder → segment register D input.

## Configuration
- HEX_LEADING_ZERO_BLANK_EN defined:
  - A sticky seen_nonzero flag is cleared on accept.
  - During SCAN, a zero nibble with seen_nonzero == 0 and idx != 0 is written as 0x7F instead of 0x40.
  - Digit 0 is never blanked.
- HEX_LEADING_ZERO_BLANK_EN undefined:
  - Every nibble is decoded literally and the flag logic is absent.
- Timing is identical in both builds.

## Structure
- Package hex_display_pkg holds:
  - state enum (IDLE, SCAN, DONE)
  - DIGIT_W = 7
  - NIBBLE_W = 4
  - SEG_BLANK = 7'h7F
- Single sub-module: one hexadigit8 instance as the shared decoder, fed from the shadow-nibble mux.
- The scheduler owns the index counter, shadow register, segment registers and handshake.

## Test plan
- Reset, then idle for 5 cycles:
  - seg_out all ones, in_ready = 1, busy = 0, done = 0.
- Accept 0x12345678 at E0:
  - Digit 7 = 0x79 at E0+1.
  - Digit 0 = 0x00 at E0+8.
  - done pulses at cycle E0+9 only.
  - in_ready = 1 at E0+10.
- Hold in_valid high with 0xFFFFFFFF, then 0xA5A5A5A5 (source-driven, changing during SCAN):
  - Only the value present on the accepting edge is displayed.
  - Final digits alternate 0x08/0x12.
- Assert rst at E0+4 of a scan of 0xDEADBEEF:
  - All digits 0x7F at the next edge.
  - IDLE, no done pulse.
- With HEX_LEADING_ZERO_BLANK_EN, accept 0x000000A5:
  - Digits 7..2 = 0x7F, digit 1 = 0x08, digit 0 = 0x12.
  - Accepting 0x00000000 gives digit 0 = 0x40 and the others 0x7F.
- Without HEX_LEADING_ZERO_BLANK_EN, accept 0x00000000:
  - All eight digits = 0x40.
